dpram_fifo_ctrl: RTL and testbench
==================================

# dpram_fifo_ctrl

FIFO controller that sits directly upstream and downstream of the 256x4 dual-port RAM (`ram_mod`). It turns the RAM's raw write/read ports into a valid/ready push interface and a first-word-fall-through pop interface. The controller owns the write pointer, the fetch pointer and the occupancy count, and it hides the RAM's one-cycle read latency with a 2-entry output buffer so it sustains one pop per cycle.

## Interface
Parameters:
- ADDR_W, 8: RAM address width; FIFO depth is 2^ADDR_W.
- DATA_W, 4: data width; must match the RAM.
- AF_MARGIN, 4: almost-full distance. Used only under DPFIFO_ALMOST_FULL_EN.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  push request.
- in_ready  out  1  controller can accept a push; equals !full.
- in_data  in  DATA_W  push data.
- out_valid  out  1  out_data holds the oldest entry.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  DATA_W  head-of-FIFO data.
- ram_write_en  out  1  to RAM write_en.
- ram_write_addr  out  ADDR_W  to RAM write_addr.
- ram_write_data  out  DATA_W  to RAM write_data.
- ram_read_en  out  1  to RAM read_en.
- ram_read_addr  out  ADDR_W  to RAM read_addr.
- ram_read_data  in  DATA_W  from RAM read_data; valid the cycle after ram_read_en.
- count  out  ADDR_W+1  total entries held, including RAM, in-flight and buffered.
- full  out  1  count == 2^ADDR_W.
- empty  out  1  count == 0.
- almost_full  out  1  present only under DPFIFO_ALMOST_FULL_EN.

## Operation
- **Push:** when in_valid & in_ready, drive ram_write_en=1, ram_write_addr=wr_ptr, ram_write_data=in_data combinationally. wr_ptr increments mod 2^ADDR_W at the edge.
- **Unfetched counter:** `unf` counts entries written to the RAM but not yet read. It increments on the push edge and decrements when a read is issued.
- **Read issue:** ram_read_en=1 and ram_read_addr=fetch_ptr when unf>0 and (buf_cnt + inflight − pop) < 2.
  - pop = out_valid & out_ready; inflight = a read was issued last cycle.
  - fetch_ptr increments mod 2^ADDR_W on issue.
- **Return:** when inflight, ram_read_data is written into the output buffer, a 2-entry FIFO of head and skid registers. out_data always shows the head register.
- **Pop:** removes the head; the skid entry moves into the head.
- **Count:** count += push, −= pop. Simultaneous push and pop leaves count unchanged.
- **Overwrite safety:** because unf ≤ count ≤ 2^ADDR_W, an unfetched RAM word is never overwritten.
- **Status flags:** full, empty and in_ready are decoded from registered count. They are not affected by same-cycle pop or push, so there is no pass-through and no bypass.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, empty=1, full=0, count=0, almost_full=0.
  - All ram_* outputs 0.
  - wr_ptr=fetch_ptr=unf=0, buffer cleared.
- Reset asserted mid-operation: at that edge all state returns to its reset value. An in-flight RAM read is discarded. RAM contents are not cleared and are not needed.
- Push latency: a push accepted at edge E gives ram_read_en high in cycle E+1 and out_valid=1 after edge E+2, if the FIFO was otherwise empty.
- Throughput: with out_ready held at 1 and a continuous stream, one pop per cycle after the initial 2-cycle fill.
- Empty: out_valid=0 and out_data holds its last value. A pop while out_valid=0 has no effect.
- Full: in_ready=0 and writes are suppressed. A pop in the same cycle lowers full only after that edge.
- Pointer wrap: wr_ptr and fetch_ptr wrap 2^ADDR_W−1 → 0 with no gap.
- out_valid and out_data stay stable while out_valid & !out_ready.

## Configuration
- DPFIFO_ALMOST_FULL_EN defined:
  - Adds the almost_full output, registered: 1 when the next-state count ≥ 2^ADDR_W − AF_MARGIN.
  - Updates on the same edge as count. Reset value 0.
- Undefined: the almost_full port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then push 0xA, 0xC, 0x3 on consecutive cycles, out_ready=1:
  - ram_write_addr is 0x00, 0x01, 0x02.
  - out_data is 0xA, 0xC, 0x3 in order; first out_valid 2 cycles after the first push.
- Push 256 entries with out_ready=0: full=1, in_ready=0 and count=256 after the 256th push. A 257th in_valid causes no ram_write_en.
- Fill to full, then push and pop every cycle for 600 cycles with data = cycle index mod 16: pointers wrap twice, and output order matches input with no loss or duplicates.
- Random out_ready stalls over 1000 random pushes: out_data stays stable while stalled, and the scoreboard matches exactly.
- Assert rst with 5 entries held and a read in flight: next cycle count=0, empty=1, out_valid=0. Then push 0x5 and see out_data=0x5 two cycles later.
- With DPFIFO_ALMOST_FULL_EN, AF_MARGIN=4: almost_full rises on the edge where count reaches 252 and falls when count drops to 251.

Source files
------------

// File: rtl/dpram_fifo_ctrl_if.sv
// dpram_fifo_ctrl_if: push (valid/ready) and first-word-fall-through pop handshake bundle.
interface dpram_fifo_ctrl_if #(parameter int DATA_W = 4);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FIFO controller around a 1-cycle-latency dual-port RAM with a 2-entry output buffer.
// Optional almost_full output enabled by defining DPFIFO_ALMOST_FULL_EN.
module dpram_fifo_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 4,
    parameter int AF_MARGIN = 4
) (
    input  logic              clk,
    input  logic              rst,
    dpram_fifo_ctrl_if.slave  bus,
    output logic              ram_write_en_o,
    output logic [ADDR_W-1:0] ram_write_addr_o,
    output logic [DATA_W-1:0] ram_write_data_o,
    output logic              ram_read_en_o,
    output logic [ADDR_W-1:0] ram_read_addr_o,
    input  logic [DATA_W-1:0] ram_read_data_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o
`ifdef DPFIFO_ALMOST_FULL_EN
    ,
    output logic              almost_full_o
`endif
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_W:0]   count_q, count_d, unf_q, unf_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d, after_pop;
    logic [DATA_W-1:0] head_q, head_d, skid_q, skid_d;
    logic              inflight_q, push, pop, issue;
    logic [2:0]        occ;

    always_comb begin
        push        = bus.in_valid & ~count_q[ADDR_W];
        pop         = (buf_cnt_q != 2'd0) & bus.out_ready;
        occ         = {1'b0, buf_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
        issue       = (unf_q != '0) && (occ < 3'd2);
        after_pop   = buf_cnt_q - {1'b0, pop};
        // returning word lands in the first free slot after this cycle's pop
        head_d      = (inflight_q && after_pop == 2'd0) ? ram_read_data_i :
                      (pop && buf_cnt_q == 2'd2) ? skid_q : head_q;
        skid_d      = (inflight_q && after_pop != 2'd0) ? ram_read_data_i : skid_q;
        buf_cnt_d   = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        count_d     = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        unf_d       = unf_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
        wr_ptr_d    = wr_ptr_q + ADDR_W'(push);
        fetch_ptr_d = fetch_ptr_q + ADDR_W'(issue);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            fetch_ptr_q <= '0;
            count_q     <= '0;
            unf_q       <= '0;
            buf_cnt_q   <= '0;
            head_q      <= '0;
            skid_q      <= '0;
            inflight_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fetch_ptr_q <= fetch_ptr_d;
            count_q     <= count_d;
            unf_q       <= unf_d;
            buf_cnt_q   <= buf_cnt_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            inflight_q  <= issue;
        end
    end

`ifdef DPFIFO_ALMOST_FULL_EN
    logic af_q;
    always_ff @(posedge clk) begin
        if (rst) af_q <= 1'b0;
        else     af_q <= count_d >= (ADDR_W+1)'(DEPTH - AF_MARGIN);
    end
    assign almost_full_o = af_q;
`endif

    assign bus.in_ready     = ~count_q[ADDR_W];
    assign bus.out_valid    = buf_cnt_q != 2'd0;
    assign bus.out_data     = head_q;
    assign ram_write_en_o   = push;
    assign ram_write_addr_o = wr_ptr_q;
    assign ram_write_data_o = push ? bus.in_data : '0;
    assign ram_read_en_o    = issue;
    assign ram_read_addr_o  = fetch_ptr_q;
    assign count_o          = count_q;
    assign full_o           = count_q == (ADDR_W+1)'(DEPTH);
    assign empty_o          = count_q == '0;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: randomized scoreboard bench with a behavioural RAM and queue reference model.
module tb_dpram_fifo_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dpram_fifo_ctrl_if #(.DATA_W(4)) bus ();
    logic       we, re;
    logic [7:0] wa, ra;
    logic [3:0] wd, rd;
    logic [8:0] count;
    logic       full, empty;
`ifdef DPFIFO_ALMOST_FULL_EN
    logic       af;
`endif

    dpram_fifo_ctrl #(.ADDR_W(8), .DATA_W(4), .AF_MARGIN(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_write_en_o(we), .ram_write_addr_o(wa), .ram_write_data_o(wd),
        .ram_read_en_o(re), .ram_read_addr_o(ra), .ram_read_data_i(rd),
        .count_o(count), .full_o(full), .empty_o(empty)
`ifdef DPFIFO_ALMOST_FULL_EN
        , .almost_full_o(af)
`endif
    );

    logic [3:0] mem [256];
    always @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rd <= mem[ra];
    end

    int          total = 0;
    int          bad = 0;
    int unsigned wcnt = 0;
    int unsigned acc = 0;
    logic [3:0]  q[$];
    logic        prev_stall = 1'b0;
    logic [3:0]  prev_data = '0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: the queue holds exactly what the FIFO should contain at each cycle boundary
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            wcnt = 0;
            prev_stall = 1'b0;
        end else begin
            check("count", int'(count), q.size());
            check("full", int'(full), int'(q.size() == 256));
            check("empty", int'(empty), int'(q.size() == 0));
            check("in_ready", int'(bus.in_ready), int'(q.size() != 256));
`ifdef DPFIFO_ALMOST_FULL_EN
            check("almost_full", int'(af), int'(q.size() >= 252));
`endif
            if (prev_stall) begin
                check("stall_valid", int'(bus.out_valid), 1);
                check("stall_data", int'(bus.out_data), int'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop: out_valid with nothing expected, data %0d at %0t", bus.out_data, $time);
                end else check("pop_data", int'(bus.out_data), int'(q.pop_front()));
            end
            if (bus.in_valid && bus.in_ready) begin
                check("wr_en", int'(we), 1);
                check("wr_addr", int'(wa), int'(wcnt % 256));
                check("wr_data", int'(wd), int'(bus.in_data));
                q.push_back(bus.in_data);
                wcnt++;
                acc++;
            end else check("wr_en_idle", int'(we), 0);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int unsigned start;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_ram", int'({we, re, wa, ra, wd}), 0);

        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 4'hA;
        @(posedge clk); #1;
        bus.in_data = 4'hC;
        check("lat_read_en", int'(re), 1);
        check("lat_read_addr", int'(ra), 0);
        @(posedge clk); #1;
        bus.in_data = 4'h3;
        check("lat_not_yet_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("lat_valid", int'(bus.out_valid), 1);
        check("lat_data", int'(bus.out_data), 4'hA);
        repeat (6) @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.in_data = 4'($urandom);
            @(posedge clk); #1;
        end
        check("fill_count", int'(count), 256);
        check("fill_full", int'(full), 1);
        check("fill_in_ready", int'(bus.in_ready), 0);
        check("fill_no_write", int'(we), 0);
        @(posedge clk); #1;

        bus.out_ready = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bus.in_data = 4'(i % 16);
            @(posedge clk); #1;
        end

        start = acc;
        cyc = 0;
        while (acc - start < 1000 && cyc < 20000) begin
            bus.in_valid = $urandom_range(0, 3) != 0;
            bus.in_data = 4'($urandom);
            bus.out_ready = $urandom_range(0, 2) != 0;
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_pushes", int'(acc - start >= 1000), 1);

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 4'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_count", int'(count), 5);
        bus.out_ready = 1'b1;
        #1;
        check("pre_rst_read", int'(re), 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_valid", int'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 4'h5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_not_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        check("post_rst_valid", int'(bus.out_valid), 1);
        check("post_rst_data", int'(bus.out_data), 5);
        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
